// File: rtl/bpsk_pkg.sv
// Shared types and default widths for the BPSK transmit controller.
// BPSK_FRAMING_EN: when defined, frames carry a start bit 0 and a stop bit 1 around the payload.
package bpsk_pkg;

    localparam int unsigned DEF_SAMPLE_WIDTH    = 12;
    localparam int unsigned DEF_CNT_WIDTH       = 8;
    localparam int unsigned DEF_DATA_WIDTH      = 8;
    localparam int unsigned DEF_PERIODS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        SEND = 2'd2
    } state_t;

    // Number of symbols transmitted per frame for a given payload width.
    function automatic int unsigned frame_len(input int unsigned data_width);
`ifdef BPSK_FRAMING_EN
        return data_width + 2;
`else
        return data_width;
`endif
    endfunction

endpackage

// File: rtl/bpsk_bit_timer.sv
// Counts carrier periods within one symbol; strobes bit_done_c on the last carrier wrap of a symbol.
module bpsk_bit_timer #(
    parameter int unsigned PERIODS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic period_end,
    output logic bit_done_c
);

    localparam int unsigned PW = (PERIODS_PER_BIT > 1) ? $clog2(PERIODS_PER_BIT) : 1;
    localparam logic [PW-1:0] LAST_PERIOD = PW'(PERIODS_PER_BIT - 1);

    logic [PW-1:0] period_cnt;

    // Symbol ends on the carrier wrap that closes its final period.
    assign bit_done_c = period_end && (period_cnt == LAST_PERIOD);

    // Period counter advances once per carrier wrap and restarts with each symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (period_end) begin
            period_cnt <= bit_done_c ? '0 : period_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/bpsk_tx_ctrl.sv
// BPSK transmit controller: accepts a payload, aligns to the carrier wrap, then emits one
// phase-selected carrier sample per cycle, MSB first.
// BPSK_FRAMING_EN: when defined, each frame is start bit 0, payload, stop bit 1.
module bpsk_tx_ctrl
    import bpsk_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned PERIODS_PER_BIT = DEF_PERIODS_PER_BIT,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] sin_in,
    input  logic [SAMPLE_WIDTH-1:0] neg_sin_in,
    input  logic [CNT_WIDTH-1:0]    cnt_in,
    output logic                    gen_en,
    output logic [SAMPLE_WIDTH-1:0] tx_data,
    output logic                    tx_valid,
    output logic                    busy
);

    localparam int unsigned FRAME_BITS = frame_len(DATA_WIDTH);
    localparam int unsigned BW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BW-1:0]        LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                  state, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_c;
    logic [BW-1:0]           bit_cnt, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] tx_data_d;
    logic                    tx_valid_d, s_ready_d, gen_en_d, busy_d;
    logic                    carrier_wrap_c, bit_done_c;

    // Frame image loaded into the shift register; its MSB is the first symbol on air.
`ifdef BPSK_FRAMING_EN
    assign frame_c = {1'b0, s_data, 1'b1};
`else
    assign frame_c = s_data;
`endif

    assign carrier_wrap_c = (state == SEND) && (cnt_in == CNT_MAX);

    // Period counting within a symbol.
    bpsk_bit_timer #(
        .PERIODS_PER_BIT (PERIODS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .period_end (carrier_wrap_c),
        .bit_done_c (bit_done_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    shift_d   = frame_c;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end
            end
            SYNC: begin
                if (cnt_in == CNT_MAX) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_data_d  = shift_q[FRAME_BITS-1] ? sin_in : neg_sin_in;
                tx_valid_d = 1'b1;
                if (bit_done_c) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == IDLE);
        gen_en_d  = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            s_ready  <= 1'b0;
            gen_en   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            shift_q  <= shift_d;
            bit_cnt  <= bit_cnt_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            s_ready  <= s_ready_d;
            gen_en   <= gen_en_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_bpsk_tx_ctrl.sv
// Self-checking bench for bpsk_tx_ctrl: two instances (1 and 2 carrier periods per bit),
// each fed by a behavioural carrier generator, checked cycle by cycle against a symbol model.
module tb_bpsk_tx_ctrl;

    localparam int unsigned SW  = 12;
    localparam int unsigned CW  = 8;
    localparam int unsigned DW  = 8;
    localparam int          PER = 256;
`ifdef BPSK_FRAMING_EN
    localparam int          NB  = DW + 2;
`else
    localparam int          NB  = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid    [2];
    logic          s_ready    [2];
    logic [SW-1:0] sin_in     [2];
    logic [SW-1:0] neg_sin_in [2];
    logic [CW-1:0] cnt_in     [2];
    logic          gen_en     [2];
    logic [SW-1:0] tx_data    [2];
    logic          tx_valid   [2];
    logic          busy       [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   gcnt     [2];
    logic gen_prev [2];

    always #5 clk = ~clk;

    bpsk_tx_ctrl #(.SAMPLE_WIDTH(SW), .CNT_WIDTH(CW), .PERIODS_PER_BIT(1), .DATA_WIDTH(DW)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .sin_in(sin_in[0]), .neg_sin_in(neg_sin_in[0]), .cnt_in(cnt_in[0]), .gen_en(gen_en[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .busy(busy[0]));

    bpsk_tx_ctrl #(.SAMPLE_WIDTH(SW), .CNT_WIDTH(CW), .PERIODS_PER_BIT(2), .DATA_WIDTH(DW)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .sin_in(sin_in[1]), .neg_sin_in(neg_sin_in[1]), .cnt_in(cnt_in[1]), .gen_en(gen_en[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .busy(busy[1]));

    // Symbols on air, first symbol in the MSB.
    function automatic logic [NB-1:0] frame_bits(input logic [DW-1:0] d);
`ifdef BPSK_FRAMING_EN
        return {1'b0, d, 1'b1};
`else
        return d;
`endif
    endfunction

    function automatic int ppb_of(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    // Carrier generator: parked at 0 while disabled, or free-running; random sample per cycle.
    task automatic drive_gen(input int sel, input bit parked);
        logic [SW-1:0] s;
        if (parked) gcnt[sel] = gen_prev[sel] ? (gcnt[sel] + 1) % PER : 0;
        else        gcnt[sel] = (gcnt[sel] + 1) % PER;
        s = SW'($urandom);
        cnt_in[sel]     = CW'(gcnt[sel]);
        sin_in[sel]     = s;
        neg_sin_in[sel] = ~s;
        gen_prev[sel]   = gen_en[sel];
    endtask

    task automatic idle_cycles(input int n, input bit parked);
        repeat (n) begin
            @(negedge clk);
            drive_gen(0, parked);
            drive_gen(1, parked);
        end
    endtask

    // Present a byte and wait (bounded) for the handshake edge.
    task automatic accept(input int sel, input logic [DW-1:0] d, input bit parked);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (s_ready[sel] === 1'b1) begin
                s_data = d;
                s_valid[sel] = 1'b1;
                got = 1;
            end
            drive_gen(sel, parked);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_wait dut%0d: s_ready never seen high, required 1 within 20 cycles", sel);
        end
    endtask

    // Follows one frame from the cycle after acceptance; stop_after>0 abandons it early.
    task automatic check_frame(input string tag, input int sel, input logic [DW-1:0] data,
                               input bit parked, input bit hold, input logic [DW-1:0] next_data,
                               input int stop_after);
        logic [NB-1:0] fb;
        logic [SW-1:0] p_sin, p_neg, exp_tx, bad_got, bad_exp;
        int  bt, total, mst, n, p_n, p_cnt, j, ph, last_ph, bad_j;
        int  err_tx, err_ctl, err_phase, n_valid, first_valid, send_j, idle_j;
        bit  p_send, exp_v, done, aborted, obs_idle;
        fb = frame_bits(data);
        bt = ppb_of(sel) * PER;
        total = NB * bt;
        mst = 1; n = 0; p_n = 0; p_cnt = 0; j = 0; last_ph = -1; bad_j = -1;
        p_send = 0; p_sin = '0; p_neg = '0; bad_got = '0; bad_exp = '0;
        err_tx = 0; err_ctl = 0; err_phase = 0; n_valid = 0;
        first_valid = -1; send_j = -1; idle_j = -1; done = 0; aborted = 0;
        while (!done) begin
            @(negedge clk);
            exp_v  = p_send;
            exp_tx = p_send ? (fb[NB-1-(p_n/bt)] ? p_sin : p_neg) : '0;
            obs_idle = (mst == 0);
            if (tx_valid[sel] !== exp_v || tx_data[sel] !== exp_tx) begin
                if (err_tx == 0) begin bad_j = j; bad_got = tx_data[sel]; bad_exp = exp_tx; end
                err_tx++;
            end
            if (busy[sel] !== (mst != 0) || gen_en[sel] !== (mst != 0) || s_ready[sel] !== (mst == 0))
                err_ctl++;
            if (tx_valid[sel] === 1'b1) begin
                n_valid++;
                if (first_valid < 0) first_valid = j;
                ph = (tx_data[sel] === p_sin) ? 1 : 0;
                if (last_ph >= 0 && ph != last_ph && p_cnt != 0) err_phase++;
                last_ph = ph;
            end
            if (busy[sel] === 1'b0 && send_j >= 0 && idle_j < 0) idle_j = j;
            if (j == 0) begin
                if (hold) begin s_valid[sel] = 1'b1; s_data = next_data; end
                else s_valid[sel] = 1'b0;
            end
            drive_gen(sel, parked);
            p_send = (mst == 2); p_n = n;
            p_sin = sin_in[sel]; p_neg = neg_sin_in[sel]; p_cnt = int'(cnt_in[sel]);
            case (mst)
                1: if (cnt_in[sel] == CW'(PER - 1)) begin mst = 2; n = 0; send_j = j + 1; end
                2: if (n == total - 1) mst = 0; else n++;
                default: ;
            endcase
            j++;
            if (obs_idle && (hold || !exp_v)) done = 1;
            if (stop_after > 0 && j >= stop_after) begin done = 1; aborted = 1; end
            if (!done && j > PER + total + 16) begin
                done = 1; aborted = 1;
                n_checks++; n_fail++;
                $display("FAIL %s timeout: frame still running after %0d cycles, required <= %0d", tag, j, PER + total + 16);
            end
        end
        n_checks++;
        if (err_tx !== 0) begin
            n_fail++;
            $display("FAIL %s tx_data: %0d bad cycles, first at %0d got %h required %h", tag, err_tx, bad_j, bad_got, bad_exp);
        end
        n_checks++;
        if (err_ctl !== 0) begin
            n_fail++;
            $display("FAIL %s busy/gen_en/s_ready: %0d bad cycles, required 0", tag, err_ctl);
        end
        if (!aborted) begin
            n_checks++;
            if (err_phase !== 0) begin
                n_fail++;
                $display("FAIL %s phase_boundary: %0d switches off the carrier wrap, required 0", tag, err_phase);
            end
            n_checks++;
            if (n_valid !== total) begin
                n_fail++;
                $display("FAIL %s tx_valid_len: got %0d cycles, required %0d", tag, n_valid, total);
            end
            n_checks++;
            if (idle_j - send_j !== total) begin
                n_fail++;
                $display("FAIL %s busy_fall: got %0d cycles after SEND entry, required %0d", tag, idle_j - send_j, total);
            end
            if (parked) begin
                n_checks++;
                if (first_valid !== PER + 1) begin
                    n_fail++;
                    $display("FAIL %s sync_len: first tx_valid %0d cycles after accept, required %0d", tag, first_valid, PER + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3, 1);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if ({tx_valid[s], busy[s], gen_en[s], s_ready[s]} !== 4'b0000 || tx_data[s] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got v%b b%b g%b r%b d%h, required all 0",
                         s, tx_valid[s], busy[s], gen_en[s], s_ready[s], tx_data[s]);
            end
        end
        rst = 1'b0;
        idle_cycles(1, 1);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (s_ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release dut%0d: got s_ready %b busy %b, required 1 0", s, s_ready[s], busy[s]);
            end
        end
    endtask

    task automatic test_pattern_a5();
        accept(0, 8'hA5, 1);
        check_frame("a5_ppb1", 0, 8'hA5, 1, 0, 8'h00, 0);
    endtask

    task automatic test_all_zero();
        accept(1, 8'h00, 1);
        check_frame("zero_ppb2", 1, 8'h00, 1, 0, 8'h00, 0);
    endtask

    task automatic test_all_ones();
        accept(1, 8'hFF, 1);
        check_frame("ones_ppb2", 1, 8'hFF, 1, 0, 8'h00, 0);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            d = DW'($urandom);
            idle_cycles($urandom_range(1, 40), 0);
            accept(k % 2, d, 0);
            check_frame("random_freerun", k % 2, d, 0, 0, 8'h00, 0);
        end
    endtask

    task automatic test_back_to_back();
        accept(0, 8'hA5, 1);
        check_frame("hold_first", 0, 8'hA5, 1, 1, 8'h3C, 0);
        check_frame("hold_second", 0, 8'h3C, 1, 0, 8'h00, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        int bad;
        d = DW'($urandom);
        accept(1, d, 1);
        check_frame("abort_prefix", 1, d, 1, 0, 8'h00, PER + 700);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_cycles(1, 1);
            n_checks++;
            if ({tx_valid[1], busy[1], gen_en[1], s_ready[1]} !== 4'b0000 || tx_data[1] !== '0) begin
                n_fail++;
                $display("FAIL midframe_reset cycle %0d: got v%b b%b g%b r%b d%h, required all 0",
                         k, tx_valid[1], busy[1], gen_en[1], s_ready[1], tx_data[1]);
            end
        end
        rst = 1'b0;
        idle_cycles(1, 1);
        n_checks++;
        if (s_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_release: got s_ready %b, required 1", s_ready[1]);
        end
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            idle_cycles(1, 1);
            if (tx_valid[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midframe_no_tail: %0d cycles with tx_valid/busy after abort, required 0", bad);
        end
    endtask

    task automatic test_reset_priority();
        idle_cycles(2, 1);
        rst = 1'b1;
        s_data = 8'h5A;
        s_valid[0] = 1'b1;
        idle_cycles(1, 1);
        n_checks++;
        if (busy[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got busy %b s_ready %b, required 0 0", busy[0], s_ready[0]);
        end
        rst = 1'b0;
        s_valid[0] = 1'b0;
        idle_cycles(2, 1);
        n_checks++;
        if (busy[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_priority_release: got busy %b s_ready %b, required 0 1", busy[0], s_ready[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0;
        for (int s = 0; s < 2; s++) begin
            s_valid[s] = 1'b0; sin_in[s] = '0; neg_sin_in[s] = '0; cnt_in[s] = '0;
            gcnt[s] = 0; gen_prev[s] = 1'b0;
        end
        test_reset();
        test_pattern_a5();
        test_all_zero();
        test_all_ones();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 1000000 time units, required earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bpsk_tx_ctrl.md
BPSK_TX_CTRL -- requirements
Module: bpsk_tx_ctrl

Interface
- REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12: carrier sample width.
- REQ-002 SHALL have parameter CNT_WIDTH, default 8: sample-index width (2^CNT_WIDTH samples per carrier period).
- REQ-003 SHALL have parameter PERIODS_PER_BIT, default 4: carrier periods per symbol (>=1).
- REQ-004 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
- REQ-005 SHALL use one clock and a synchronous, active-high reset.
- REQ-006 SHALL have port clk  in  1: clock; all state changes on its rising edge.
- REQ-007 SHALL have port rst  in  1: synchronous active-high reset.
- REQ-008 SHALL have port s_data  in  DATA_WIDTH: payload byte.
- REQ-009 SHALL have port s_valid  in  1: s_data valid.
- REQ-010 SHALL have port s_ready  out  1: controller accepts s_data.
- REQ-011 SHALL have port sin_in  in  SAMPLE_WIDTH: generator sine sample.
- REQ-012 SHALL have port neg_sin_in  in  SAMPLE_WIDTH: generator inverted sine sample.
- REQ-013 SHALL have port cnt_in  in  CNT_WIDTH: generator sample index.
- REQ-014 SHALL have port gen_en  out  1: generator enable.
- REQ-015 SHALL have port tx_data  out  SAMPLE_WIDTH: modulated sample.
- REQ-016 SHALL have port tx_valid  out  1: tx_data valid.
- REQ-017 SHALL have port busy  out  1: frame in progress (state != IDLE).

Function
- REQ-018 SHALL implement FSM IDLE -> SYNC -> SEND -> IDLE.
- REQ-019 IDLE: s_ready=1, gen_en=0; on s_valid&&s_ready, SHALL latch the frame into a shift register and go to SYNC.
- REQ-020 SHALL hold s_ready=0 outside IDLE; s_valid there is ignored and the byte is not consumed.
- REQ-021 SYNC: gen_en=1, tx_valid=0; SHALL go to SEND on the cycle cnt_in == 2^CNT_WIDTH-1 (CNT_MAX), so SEND starts at cnt_in==0.
- REQ-022 SEND: gen_en=1; SHALL register tx_data <= current bit ? sin_in : neg_sin_in and tx_valid <= 1 (one-cycle latency).
- REQ-023 SHALL send bits MSB first; bit 1 selects sin_in, bit 0 selects neg_sin_in.
- REQ-024 Period counter SHALL increment on each SEND cycle with cnt_in==CNT_MAX; when at PERIODS_PER_BIT-1, it SHALL wrap to 0, shift the register, and increment the bit counter.
- REQ-025 Phase changes SHALL occur only at carrier wrap (cnt_in CNT_MAX -> 0).
- REQ-026 After the last bit's final CNT_MAX cycle, SHALL go to IDLE; gen_en=0 and s_ready=1 on the next cycle; tx_valid falls one cycle later.
- REQ-027 Outside SEND, the registered tx_data SHALL be 0.
- REQ-028 Bit time = PERIODS_PER_BIT*2^CNT_WIDTH cycles exactly.

Reset
- REQ-029 On rst: state=IDLE, s_ready=0 during reset, then 1 after the reset cycle; gen_en=0, tx_data=0, tx_valid=0, busy=0, counters and shift register=0.
- REQ-030 rst mid-frame SHALL abort the frame at the next edge and discard the remaining bits; no partial symbol follows.
- REQ-031 rst SHALL take priority over a simultaneous s_valid handshake.

Configuration
- REQ-032 Macro BPSK_FRAMING_EN defined: frame = start bit 0, DATA_WIDTH payload bits MSB first, stop bit 1 (DATA_WIDTH+2 symbols).
- REQ-033 Macro BPSK_FRAMING_EN undefined: frame = DATA_WIDTH payload bits only; the bit counter is sized accordingly.

Structure
- REQ-034 Package bpsk_pkg SHALL hold the state typedef (IDLE/SYNC/SEND) and the default SAMPLE_WIDTH/CNT_WIDTH/DATA_WIDTH constants.
- REQ-035 Sub-module bpsk_bit_timer SHALL hold the period counter and emit a one-cycle bit_done strobe.

Verification
- REQ-036 Reset: assert rst 3 cycles during SEND -> all outputs 0 on the next edge; s_ready=1 after release.
- REQ-037 Byte 0xA5, framing off, PERIODS_PER_BIT=1, CNT_WIDTH=8, generator parked at cnt 0 -> SYNC lasts 256 cycles; tx_valid high for 8*256 cycles; symbol phases sin,neg,sin,neg,neg,sin,neg,sin.
- REQ-038 Phase boundary: each symbol change occurs exactly where the model's cnt_in wraps 255 -> 0; no mid-period switch.
- REQ-039 Handshake: s_valid held high with a second byte 0x3C during the frame -> not accepted until IDLE; then accepted in the first IDLE cycle.
- REQ-040 BPSK_FRAMING_EN with 0xFF, PERIODS_PER_BIT=2 -> 10 symbols of 512 cycles: first neg, next 9 sin.
- REQ-041 Byte 0x00, framing off -> 8 symbols all neg_sin_in; busy falls exactly 8*PERIODS_PER_BIT*256 cycles after SEND entry.
